// File: rtl/serial_receiver.sv
// serial_receiver: 8N1-style asynchronous receiver, MSB-first data bits.
// The line is synchronised, the start bit is confirmed at mid-bit, data
// and stop bits are sampled at one-bit intervals from there, and the
// good byte lands in a single holding register with overrun/frame-error
// status. A bad stop bit parks the FSM until the line returns high, so a
// held-low break cannot start new frames.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | counting to mid start bit, confirming it is still low
// DATA      | sampling 8 data bits, one per bit period, MSB first
// STOP      | sampling the stop bit; decides good frame / frame error
// WAIT_HIGH | after a bad stop bit, waiting for the line to go high
module serial_receiver #(
    parameter int DELAY_TIME = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int PERIOD = DELAY_TIME + 2;
    localparam int HALF   = PERIOD / 2;

    localparam logic [9:0] CNT_HALF_END = 10'(HALF - 1);
    localparam logic [9:0] CNT_BIT_END  = 10'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        sync_1;
    logic        rx_s;
    logic [1:0]  sync_fresh;
    logic        armed;

    logic [9:0]  cnt;
    logic [2:0]  bitn;
    logic [7:0]  shreg;

    logic        half_end;
    logic        bit_end;
    logic        frame_good;
    logic        frame_bad;

    // Two-flop synchroniser; both flops preset high so reset looks like an idle line.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx_in;
            rx_s   <= sync_1;
        end
    end

    // Arm frame detection only once a genuinely high line has been observed
    // after reset: the forced-high synchroniser contents must first be flushed,
    // otherwise a line that is low at reset release would look like a new start.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_fresh <= 2'b00;
            armed      <= 1'b0;
        end else begin
            sync_fresh <= {sync_fresh[0], 1'b1};
            if (sync_fresh[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign half_end = (cnt == CNT_HALF_END);
    assign bit_end  = (cnt == CNT_BIT_END);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (armed && !rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (half_end) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bitn == 3'd7)) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_next = rx_s ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM output decode: busy plus the frame-completion strobes.
    always_comb begin
        busy       = (state != S_IDLE);
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if ((state == S_STOP) && bit_end) begin
            frame_good = rx_s;
            frame_bad  = !rx_s;
        end
    end

    // Bit timing counter, bit index and receive shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= 10'd0;
            bitn  <= 3'd0;
            shreg <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt  <= 10'd0;
                    bitn <= 3'd0;
                end
                S_START: begin
                    if (half_end) begin
                        cnt  <= 10'd0;
                        bitn <= 3'd0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt   <= 10'd0;
                        bitn  <= bitn + 3'd1;
                        shreg <= {shreg[6:0], rx_s};
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= 10'd0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    cnt <= 10'd0;
                end
                default: begin
                    cnt  <= 10'd0;
                    bitn <= 3'd0;
                end
            endcase
        end
    end

    // Holding register and status flags; a simultaneous read frees the
    // register for the arriving byte, otherwise the new byte is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out  <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (frame_good) begin
            frame_err <= 1'b0;
            if (!rdy || rd) begin
                data_out <= shreg;
                rdy      <= 1'b1;
                overrun  <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else begin
            if (frame_bad) begin
                frame_err <= 1'b1;
            end
            if (rd && rdy) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed scenarios plus random frames, checked
// every cycle against an event-level model (frame completes 1009 edges after
// the first edge that registers the start bit).
module tb_serial_receiver;

    localparam int PERIOD = 106;
    localparam int BIG    = 32'h7fff_ffff;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       rd    = 1'b0;
    logic [7:0] data_out;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    serial_receiver #(.DELAY_TIME(104)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_in    (rx_in),
        .rd       (rd),
        .data_out (data_out),
        .rdy      (rdy),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    bit   rd_rand_en = 1'b0;

    logic [7:0] m_data = 8'h00;
    logic       m_rdy  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    int         ev_edge = -1;
    logic       ev_good = 1'b0;
    logic [7:0] ev_byte = 8'h00;
    int         busy_from = 0;
    int         busy_to   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: holding-register rules applied at the scheduled completion edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_data <= 8'h00;
            m_rdy  <= 1'b0;
            m_ferr <= 1'b0;
            m_ovr  <= 1'b0;
        end else if ((ev_edge == cyc + 1) && ev_good) begin
            m_ferr <= 1'b0;
            if (!m_rdy || rd) begin
                m_data <= ev_byte;
                m_rdy  <= 1'b1;
                m_ovr  <= 1'b0;
            end else begin
                m_ovr <= 1'b1;
            end
        end else begin
            if (ev_edge == cyc + 1) m_ferr <= 1'b1;
            if (rd && m_rdy) begin
                m_rdy <= 1'b0;
                m_ovr <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("rdy", 32'(rdy), 32'(m_rdy));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc < busy_to)));
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit rd_stop,
                              input int rst_bit, input bit pin);
        int k;
        logic bv;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < PERIOD; j++) begin
                @(negedge clock);
                if (i == 0 && j == 0) begin
                    k = cyc + 1;
                    ev_edge = k + 1009;
                    ev_good = stop;
                    ev_byte = b;
                    busy_from = k + 2;
                    busy_to = stop ? k + 1009 : BIG;
                end
                if (i == 0) bv = 1'b0;
                else if (i == 9) bv = stop;
                else bv = b[8-i];
                rx_in = bv;
                if (i == rst_bit && j == 20) begin
                    reset = 1'b1;
                    ev_edge = -1;
                    busy_to = cyc + 1;
                end else begin
                    reset = 1'b0;
                end
                if (rd_stop && i == 9 && j == 55) rd = 1'b1;
                else rd = rd_rand_en ? ($urandom_range(63) == 0) : 1'b0;
                if (pin && i == 9 && j == 55) chk("pin_rdy_before_stop", 32'(rdy), 32'd0);
                if (pin && i == 9 && j == 56) begin
                    chk("pin_rdy_at_stop", 32'(rdy), 32'd1);
                    chk("pin_data_at_stop", 32'(data_out), 32'(b));
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic level);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (level && !rx_in && busy_to == BIG) busy_to = cyc + 3;
            rx_in = level;
            reset = 1'b0;
            rd = rd_rand_en ? ($urandom_range(63) == 0) : 1'b0;
        end
    endtask

    task automatic glitch();
        int k;
        for (int j = 0; j < 70; j++) begin
            @(negedge clock);
            if (j == 0) begin
                k = cyc + 1;
                busy_from = k + 2;
                busy_to = k + 55;
            end
            rx_in = (j >= 20);
            rd = rd_rand_en ? ($urandom_range(63) == 0) : 1'b0;
            if (!rd_rand_en && j == 55) chk("glitch_busy_before_sample", 32'(busy), 32'd1);
            if (!rd_rand_en && j == 56) chk("glitch_busy_after_sample", 32'(busy), 32'd0);
        end
    endtask

    task automatic pulse_rd();
        @(negedge clock);
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        repeat (5) @(negedge clock);
        chk_en = 1'b1;
        reset = 1'b0;
        idle(20, 1'b1);
        chk("reset_data", 32'(data_out), 32'h00);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_ferr", 32'(frame_err), 32'd0);
        chk("reset_ovr", 32'(overrun), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_rdy", 32'(rdy), 32'd1);
        chk("a5_ferr", 32'(frame_err), 32'd0);
        chk("a5_busy", 32'(busy), 32'd0);

        idle(10, 1'b1);
        glitch();
        chk("glitch_data", 32'(data_out), 32'hA5);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        pulse_rd();
        chk("rd_clears_rdy", 32'(rdy), 32'd0);

        idle(10, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        idle(300, 1'b0);
        chk("break_ferr", 32'(frame_err), 32'd1);
        chk("break_rdy", 32'(rdy), 32'd0);
        chk("break_busy", 32'(busy), 32'd1);
        idle(50, 1'b1);
        chk("break_released_busy", 32'(busy), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, -1, 1'b1);
        chk("after_break_data", 32'(data_out), 32'h81);
        chk("after_break_ferr", 32'(frame_err), 32'd0);

        pulse_rd();
        idle(10, 1'b1);
        send_frame(8'h11, 1'b1, 1'b0, -1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, -1, 1'b0);
        chk("ovr_data", 32'(data_out), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'd1);
        pulse_rd();
        chk("ovr_rd_rdy", 32'(rdy), 32'd0);
        chk("ovr_rd_flag", 32'(overrun), 32'd0);

        idle(10, 1'b1);
        send_frame(8'h11, 1'b1, 1'b0, -1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1, -1, 1'b0);
        chk("rd_same_edge_data", 32'(data_out), 32'h22);
        chk("rd_same_edge_rdy", 32'(rdy), 32'd1);
        chk("rd_same_edge_ovr", 32'(overrun), 32'd0);

        idle(10, 1'b1);
        send_frame(8'h00, 1'b1, 1'b0, 4, 1'b0);
        chk("midreset_data", 32'(data_out), 32'h00);
        chk("midreset_rdy", 32'(rdy), 32'd0);
        chk("midreset_ferr", 32'(frame_err), 32'd0);
        chk("midreset_ovr", 32'(overrun), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        idle(30, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b1);
        chk("post_reset_data", 32'(data_out), 32'h5A);

        rd_rand_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(9) == 0) begin
                glitch();
            end else begin
                b = 8'($urandom);
                stop = ($urandom_range(7) != 0);
                send_frame(b, stop, 1'b0, -1, 1'b0);
                if (!stop) idle(int'($urandom_range(150)), 1'b0);
            end
            idle(int'($urandom_range(120, 1)), 1'b1);
        end
        rd_rand_en = 1'b0;
        idle(20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter: DELAY_TIME, default 104, sets bit period PERIOD = DELAY_TIME+2 clocks (106) and half period HALF = PERIOD/2 (53).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 Port: rx_in  input  1  asynchronous serial line; idles high.
REQ-005 Port: rd  input  1  consumer read strobe; accepted when rdy=1.
REQ-006 Port: data_out  output  8  last good received byte.
REQ-007 Port: rdy  output  1  holding register full.
REQ-008 Port: frame_err  output  1  last frame had a bad stop bit.
REQ-009 Port: overrun  output  1  good frame arrived while holding register full.
REQ-010 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer; rx_s is the second flop's output, and all decisions below use rx_s.
REQ-012 Frame format SHALL be: start bit 0, then 8 data bits MSB first (first data bit is data_out[7]), then stop bit 1; each bit lasts PERIOD clocks.
REQ-013 The FSM SHALL have 5 states (IDLE, START, DATA, STOP, WAIT_HIGH), a 10-bit bit counter cnt and a 3-bit index bitn.
REQ-014 IDLE SHALL move to START with cnt=0 on the first edge where rx_s=0.
REQ-015 START SHALL increment cnt each edge; at the edge where cnt=HALF-1 it samples rx_s: 0 -> DATA with cnt=0 and bitn=0; 1 -> IDLE (glitch rejected, no status change).
REQ-016 DATA SHALL sample rx_s at cnt=PERIOD-1, shift it into the LSB of an 8-bit shift register (shift left), reset cnt to 0 and increment bitn; after the 8th sample it moves to STOP.
REQ-017 STOP SHALL sample rx_s at cnt=PERIOD-1; on 1 the frame is good -> IDLE; on 0 it sets frame_err=1, discards the byte -> WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL remain until rx_s=1, then go to IDLE; a held-low line (break) SHALL not start new frames.
REQ-019 Good frame with rdy=0, or with rdy=1 and rd=1 on the same edge: data_out SHALL load the byte, rdy=1 and frame_err=0.
REQ-020 Good frame with rdy=1 and rd=0: data_out SHALL keep the old byte, new byte discarded, overrun=1, frame_err=0.
REQ-021 rd with rdy=1 and no simultaneous good-frame load SHALL clear rdy and overrun on that edge; rd with rdy=0 is ignored.
REQ-022 Latency: if edge k is the first edge registering rx_in=0, the START sample SHALL occur at k+55, data samples at k+55+106*i (i=1..8), and the stop sample at k+1009; rdy/frame_err change at edge k+1009.
REQ-023 data_out, rdy, frame_err and overrun SHALL be registered outputs, and busy SHALL be decoded from the state register.

Reset
REQ-024 reset=1 SHALL force state=IDLE, cnt=0, bitn=0, shift register=0, data_out=0x00, rdy=0, frame_err=0, overrun=0, and both synchronizer flops=1; reset SHALL take priority over all other activity, including mid-frame.
REQ-025 After reset deasserts, a frame SHALL be recognised only from a new falling edge on rx_in.

Verification
REQ-026 Frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,1 at 106 clk/bit), rd=0 -> rdy rises at k+1009, data_out=0xA5, frame_err=0, busy low afterwards.
REQ-027 rx_in low for 20 clocks then high -> no rdy, frame_err=0, state returns to IDLE by k+55.
REQ-028 Frame 0x3C with stop bit 0, line held low 300 clocks, then high -> frame_err=1, rdy=0, no new frame during the low period; a following 0x81 frame -> data_out=0x81, frame_err=0.
REQ-029 Frames 0x11 then 0x22 with no rd -> data_out=0x11, overrun=1; rd pulse -> rdy=0, overrun=0.
REQ-030 rd asserted on the exact edge 0x22 completes (rdy=1 holding 0x11) -> data_out=0x22, rdy=1, overrun=0.
REQ-031 reset pulsed during data bit 4 of a frame -> all outputs 0, busy=0; remainder of that frame is ignored; next full frame 0x5A is received correctly.
